apb_slave_mem: RTL and testbench

//  APB completer (slave) that terminates the bus driven by the APB master/driver.

---
 rtl/apb_slave_mem.sv | 130 +++++++++++++
 tb/tb_apb_slave_mem.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer backed by a DEPTH-word register memory.
// Each transfer is a setup edge (IDLE -> ACCESS) followed by WAIT_STATES
// pready-low cycles and a completion edge. Out-of-range word indices get a
// full handshake with pslverr=1. A write never changes the memory, and a
// read returns zero.
module apb_slave_mem #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                  pclk,
    input  logic                  prst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [WIDTH-1:0]      pwdata,
    output logic                  pready,
    output logic [WIDTH-1:0]      prdata,
    output logic                  pslverr
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              AW1       = ADDR_WIDTH + 1;
    // One extra bit so that DEPTH == 2**ADDR_WIDTH still fits the bound.
    localparam logic [AW1-1:0]  DEPTH_LIM = AW1'(DEPTH);
    localparam logic [3:0]      WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic             write_q;
    logic             err_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             setup_edge;
    logic             complete_edge;
    logic             addr_err;
    logic [IDX_W-1:0] idx_in;

    assign idx_in   = paddr[IDX_W-1:0];
    assign addr_err = ({1'b0, paddr} >= DEPTH_LIM);

    // Next-state and registered-only response decode.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        pready        = 1'b0;
        pslverr       = 1'b0;
        setup_edge    = 1'b0;
        complete_edge = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d    = ACCESS;
                    setup_edge = 1'b1;
                end
            end
            ACCESS: begin
                pready  = (cnt_q == 4'd0);
                pslverr = err_q && (cnt_q == 4'd0);
                if (!(psel && penable)) begin
                    // The master abandoned the transfer; nothing is written.
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d       = IDLE;
                    complete_edge = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the request on the setup edge, count down wait states, and
    // fetch read data once so that prdata holds until the next read.
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            prdata  <= '0;
        end else if (setup_edge) begin
            cnt_q   <= WAIT_INIT;
            idx_q   <= idx_in;
            write_q <= pwrite;
            err_q   <= addr_err;
            wdata_q <= pwdata;
            if (!pwrite) begin
                prdata <= addr_err ? '0 : mem[idx_in];
            end
        end else if ((state_q == ACCESS) && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Storage array: commits a write only on a clean completion edge.
    // NOTE: the memory is built from resettable flops because reset must
    // clear every word; a RAM macro without reset would not meet that.
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (complete_edge && write_q && !err_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: three completers (WAIT_STATES 0, 2, 3) on separate buses,
// driven by directed and random transfers and compared against an
// array-based model of the memory and of the held read data.
module tb_apb_slave_mem;

    localparam int N     = 3;
    localparam int DEPTH = 16;

    logic        pclk;
    logic        prst;
    logic        psel    [N];
    logic        penable [N];
    logic        pwrite  [N];
    logic [7:0]  paddr   [N];
    logic [31:0] pwdata  [N];
    logic        pready  [N];
    logic [31:0] prdata  [N];
    logic        pslverr [N];

    logic [31:0] model_mem [N][DEPTH];
    logic [31:0] model_rd  [N];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        apb_slave_mem #(
            .ADDR_WIDTH (8),
            .WIDTH      (32),
            .DEPTH      (DEPTH),
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) u_dut (
            .pclk   (pclk),
            .prst   (prst),
            .psel   (psel[g]),
            .penable(penable[g]),
            .pwrite (pwrite[g]),
            .paddr  (paddr[g]),
            .pwdata (pwdata[g]),
            .pready (pready[g]),
            .prdata (prdata[g]),
            .pslverr(pslverr[g])
        );
    end

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < N; k++) begin
            model_rd[k] = '0;
            for (int a = 0; a < DEPTH; a++) model_mem[k][a] = '0;
        end
    endtask

    task automatic bus_idle(input int k);
        @(negedge pclk);
        psel[k]    = 1'b0;
        penable[k] = 1'b0;
    endtask

    // One complete transfer; returns with the completion edge pending.
    task automatic xfer(input int k, input bit wr, input logic [7:0] addr, input logic [31:0] data);
        int          lows;
        bit          err;
        logic [31:0] exp_rd;
        @(negedge pclk);
        psel[k]    = 1'b1;
        penable[k] = 1'b0;
        pwrite[k]  = wr;
        paddr[k]   = addr;
        pwdata[k]  = data;
        check($sformatf("d%0d setup_pready", k), 32'(pready[k]), 32'd0);
        @(negedge pclk);
        penable[k] = 1'b1;
        // Scramble address/data: the completer must use the setup values.
        paddr[k]   = 8'($urandom);
        pwdata[k]  = $urandom;
        lows = 0;
        while (pready[k] !== 1'b1 && lows < 40) begin
            lows++;
            @(negedge pclk);
        end
        if (lows >= 40) check($sformatf("d%0d pready_timeout", k), 32'(pready[k]), 32'd1);
        err    = (addr >= DEPTH);
        exp_rd = wr ? model_rd[k] : (err ? 32'd0 : model_mem[k][addr[3:0]]);
        check($sformatf("d%0d wait_cycles a=%0d", k, addr), 32'(lows), 32'(ws_of(k)));
        check($sformatf("d%0d pslverr a=%0d", k, addr), 32'(pslverr[k]), 32'(err));
        check($sformatf("d%0d prdata %s a=%0d", k, wr ? "wr" : "rd", addr), prdata[k], exp_rd);
        if (!wr) model_rd[k] = exp_rd;
        if (wr && !err) model_mem[k][addr[3:0]] = data;
    endtask

    initial begin
        prst = 1'b1;
        for (int k = 0; k < N; k++) begin
            psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
            paddr[k] = '0;  pwdata[k] = '0;
        end
        clear_model();
        #2 prst = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            check($sformatf("d%0d reset pready", k), 32'(pready[k]), 32'd0);
            check($sformatf("d%0d reset prdata", k), prdata[k], 32'd0);
            check($sformatf("d%0d reset pslverr", k), 32'(pslverr[k]), 32'd0);
        end
        repeat (2) @(negedge pclk);
        prst = 1'b1;

        // Basic write then read with no wait states.
        xfer(0, 1'b1, 8'd3, 32'hDEADBEEF);
        xfer(0, 1'b0, 8'd3, 32'h0);
        bus_idle(0);

        // Three wait states, read of an untouched word.
        xfer(2, 1'b0, 8'd5, 32'h0);
        bus_idle(2);

        // Out-of-range write and read, then confirm word 0 untouched.
        xfer(0, 1'b1, 8'd16, 32'h12345678);
        xfer(0, 1'b0, 8'd16, 32'h0);
        xfer(0, 1'b0, 8'd0, 32'h0);
        bus_idle(0);

        // Back-to-back transfers with no idle cycle.
        xfer(1, 1'b1, 8'd1, 32'hAAAA5555);
        xfer(1, 1'b1, 8'd2, 32'hB0B0C1C1);
        xfer(1, 1'b0, 8'd1, 32'h0);
        xfer(1, 1'b0, 8'd2, 32'h0);
        bus_idle(1);

        // Abort: psel dropped in the second ACCESS cycle of a write.
        @(negedge pclk);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 8'd7; pwdata[1] = 32'hFF;
        @(negedge pclk);
        penable[1] = 1'b1;
        check("abort acc1 pready", 32'(pready[1]), 32'd0);
        @(negedge pclk);
        check("abort acc2 pready", 32'(pready[1]), 32'd0);
        psel[1] = 1'b0; penable[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            check($sformatf("abort idle%0d pready", i), 32'(pready[1]), 32'd0);
        end
        xfer(1, 1'b0, 8'd7, 32'h0);
        bus_idle(1);

        // Randomized traffic, with occasional idle gaps between transfers.
        for (int k = 0; k < N; k++) begin
            for (int n = 0; n < 60; n++) begin
                xfer(k, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 19)), $urandom);
                if ($urandom_range(0, 3) == 0) bus_idle(k);
            end
            bus_idle(k);
        end

        // Reset in the middle of a write whose pready is already high.
        xfer(0, 1'b1, 8'd9, 32'hA5A5A5A5);
        xfer(0, 1'b0, 8'd9, 32'h0);
        bus_idle(0);
        @(negedge pclk);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 8'd4; pwdata[0] = 32'h11223344;
        @(negedge pclk);
        penable[0] = 1'b1;
        check("pre-reset pready", 32'(pready[0]), 32'd1);
        #2 prst = 1'b0;
        #1;
        check("async reset pready", 32'(pready[0]), 32'd0);
        check("async reset prdata", prdata[0], 32'd0);
        check("async reset pslverr", 32'(pslverr[0]), 32'd0);
        for (int k = 0; k < N; k++) begin
            psel[k] = 1'b0; penable[k] = 1'b0;
        end
        clear_model();
        @(negedge pclk);
        prst = 1'b1;
        xfer(0, 1'b0, 8'd4, 32'h0);
        xfer(0, 1'b0, 8'd9, 32'h0);
        bus_idle(0);
        for (int k = 1; k < N; k++) begin
            for (int a = 0; a < 4; a++) xfer(k, 1'b0, 8'($urandom_range(0, 15)), 32'h0);
            bus_idle(k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
